// File: rtl/pong_frame_ctrl.sv
// pong_frame_ctrl: frame-stepped Pong game state (paddles, ball, scores) and registered pixel renderer; define PONG_AI_EN for a computer-driven right paddle
module pong_frame_ctrl #(
  parameter int PADDLE_H    = 60,
  parameter int PADDLE_W    = 8,
  parameter int BALL_SZ     = 8,
  parameter int PADDLE_STEP = 4,
  parameter int BALL_STEP   = 2
) (
  input  logic       vga_clk,
  input  logic       rst_n,
  input  logic [9:0] hsp,
  input  logic [9:0] vsp,
  input  logic       disparea,
  input  logic [4:0] btn,
  output logic [3:0] vga_r,
  output logic [3:0] vga_g,
  output logic [3:0] vga_b,
  output logic [3:0] score1,
  output logic [3:0] score2,
  output logic       game_over
);
  typedef enum logic [2:0] {WAIT, PADDLE, BALL, HIT, SCORE, OVER} state_t;
  localparam logic signed [10:0] PY_MAX = 11'(480 - PADDLE_H);
  localparam logic signed [10:0] PY_RST = 11'((480 - PADDLE_H) / 2);
  localparam logic signed [10:0] BY_MAX = 11'(480 - BALL_SZ);
  localparam logic signed [10:0] BX_MAX = 11'(640 - BALL_SZ);
  localparam logic signed [10:0] L_EDGE = 11'(16 + PADDLE_W);
  localparam logic signed [10:0] R_EDGE = 11'(616 - BALL_SZ);
  localparam logic signed [10:0] CX     = 11'sd316;
  localparam logic signed [10:0] CY     = 11'sd236;
  localparam logic signed [10:0] PS     = 11'(PADDLE_STEP);
  localparam logic signed [10:0] BS     = 11'(BALL_STEP);
  localparam logic signed [10:0] PH     = 11'(PADDLE_H);
  localparam logic signed [10:0] PW     = 11'(PADDLE_W);
  localparam logic signed [10:0] BZ     = 11'(BALL_SZ);

  state_t state_q, state_d;
  logic signed [10:0] p1_y_q, p1_y_d, p2_y_q, p2_y_d, ball_x_q, ball_x_d, ball_y_q, ball_y_d;
  logic dx_q, dx_d, dy_q, dy_d;
  logic [3:0] score1_q, score1_d, score2_q, score2_d, col_q, col_d;
  logic [4:0] btn_m_q, btn_s_q;
  logic serve_q, serve_rise, frame_tick, p2_up, p2_dn;
  logic signed [10:0] hx, vy;
  logic in_ball, in_p1, in_p2, ctr;

  // one paddle step with clamping to the playfield; opposing buttons cancel
  function automatic logic signed [10:0] pmove(input logic signed [10:0] y, input logic up, input logic dn);
    logic signed [10:0] n;
    n = (up && !dn) ? y - PS : (dn && !up) ? y + PS : y;
    return n < 0 ? 11'sd0 : n > PY_MAX ? PY_MAX : n;
  endfunction

  // true when the ball's rows overlap a paddle's rows
  function automatic logic rows_hit(input logic signed [10:0] by, input logic signed [10:0] py);
    return by < py + PH && by + BZ > py;
  endfunction

  assign frame_tick = vsp == 10'd480 && hsp == 10'd0;
  assign serve_rise = btn_s_q[4] && !serve_q;

`ifdef PONG_AI_EN
  logic signed [10:0] p2_c, tgt;
  assign p2_c  = p2_y_q + 11'(PADDLE_H / 2);
  assign tgt   = ball_y_q + 11'(BALL_SZ / 2);
  assign p2_up = tgt < p2_c - PS;
  assign p2_dn = tgt > p2_c + PS;
`else
  assign p2_up = btn_s_q[2];
  assign p2_dn = btn_s_q[3];
`endif

  // two-flop synchroniser on the raw buttons plus serve edge history
  always_ff @(posedge vga_clk or negedge rst_n)
    if (!rst_n) begin
      btn_m_q <= '0;
      btn_s_q <= '0;
      serve_q <= 1'b0;
    end else begin
      btn_m_q <= btn;
      btn_s_q <= btn_m_q;
      serve_q <= btn_s_q[4];
    end

  // per-frame game sequence: paddles, ball motion, collisions, scoring
  always_comb begin
    state_d  = state_q;
    p1_y_d   = p1_y_q;
    p2_y_d   = p2_y_q;
    ball_x_d = ball_x_q;
    ball_y_d = ball_y_q;
    dx_d     = dx_q;
    dy_d     = dy_q;
    score1_d = score1_q;
    score2_d = score2_q;
    case (state_q)
      WAIT: state_d = frame_tick ? PADDLE : WAIT;
      PADDLE: begin
        p1_y_d  = pmove(p1_y_q, btn_s_q[0], btn_s_q[1]);
        p2_y_d  = pmove(p2_y_q, p2_up, p2_dn);
        state_d = BALL;
      end
      BALL: begin
        ball_x_d = ball_x_q + (dx_q ? BS : -BS);
        ball_y_d = ball_y_q + (dy_q ? BS : -BS);
        state_d  = HIT;
      end
      HIT: begin
        if (ball_y_q <= 0) begin
          dy_d     = 1'b1;
          ball_y_d = 11'sd0;
        end else if (ball_y_q >= BY_MAX) begin
          dy_d     = 1'b0;
          ball_y_d = BY_MAX;
        end
        if (!dx_q && ball_x_q <= L_EDGE && rows_hit(ball_y_q, p1_y_q)) begin
          dx_d     = 1'b1;
          ball_x_d = L_EDGE;
        end else if (dx_q && ball_x_q >= R_EDGE && rows_hit(ball_y_q, p2_y_q)) begin
          dx_d     = 1'b0;
          ball_x_d = R_EDGE;
        end
        state_d = SCORE;
      end
      SCORE: begin
        if (ball_x_q <= 0) begin
          score2_d = score2_q + 4'd1;
          ball_x_d = CX;
          ball_y_d = CY;
          dx_d     = 1'b0;
        end else if (ball_x_q >= BX_MAX) begin
          score1_d = score1_q + 4'd1;
          ball_x_d = CX;
          ball_y_d = CY;
          dx_d     = 1'b1;
        end
        state_d = (score1_d == 4'd9 || score2_d == 4'd9) ? OVER : WAIT;
      end
      OVER: begin
        if (serve_rise) begin
          score1_d = 4'd0;
          score2_d = 4'd0;
          state_d  = WAIT;
        end else if (frame_tick) begin
          p1_y_d = pmove(p1_y_q, btn_s_q[0], btn_s_q[1]);
          p2_y_d = pmove(p2_y_q, p2_up, p2_dn);
        end
      end
      default: state_d = WAIT;
    endcase
  end

  // game state registers; reset drops any half-finished frame update
  always_ff @(posedge vga_clk or negedge rst_n)
    if (!rst_n) begin
      state_q  <= WAIT;
      p1_y_q   <= PY_RST;
      p2_y_q   <= PY_RST;
      ball_x_q <= CX;
      ball_y_q <= CY;
      dx_q     <= 1'b1;
      dy_q     <= 1'b1;
      score1_q <= 4'd0;
      score2_q <= 4'd0;
    end else begin
      state_q  <= state_d;
      p1_y_q   <= p1_y_d;
      p2_y_q   <= p2_y_d;
      ball_x_q <= ball_x_d;
      ball_y_q <= ball_y_d;
      dx_q     <= dx_d;
      dy_q     <= dy_d;
      score1_q <= score1_d;
      score2_q <= score2_d;
    end

  assign hx      = signed'({1'b0, hsp});
  assign vy      = signed'({1'b0, vsp});
  assign in_ball = hx >= ball_x_q && hx < ball_x_q + BZ && vy >= ball_y_q && vy < ball_y_q + BZ;
  assign in_p1   = hx >= 11'sd16 && hx < 11'sd16 + PW && vy >= p1_y_q && vy < p1_y_q + PH;
  assign in_p2   = hx >= 11'sd616 && hx < 11'sd616 + PW && vy >= p2_y_q && vy < p2_y_q + PH;
  assign ctr     = hsp >= 10'd318 && hsp <= 10'd321 && !vsp[3];

  // grey level for the current pixel: objects over the dashed centre line
  always_comb begin
    col_d = !disparea ? 4'h0 : (in_ball || in_p1 || in_p2) ? 4'hF : ctr ? 4'h8 : 4'h0;
  end

  // registered pixel colour, one cycle behind hsp/vsp
  always_ff @(posedge vga_clk or negedge rst_n)
    if (!rst_n) col_q <= 4'h0;
    else col_q <= col_d;

  assign vga_r     = col_q;
  assign vga_g     = col_q;
  assign vga_b     = col_q;
  assign score1    = score1_q;
  assign score2    = score2_q;
  assign game_over = score1_q == 4'd9 || score2_q == 4'd9;
endmodule

// File: tb/tb_pong_frame_ctrl.sv
// tb_pong_frame_ctrl: randomized play of pong_frame_ctrl against a per-frame behavioural game model
module tb_pong_frame_ctrl;
  logic vga_clk = 1'b0;
  logic rst_n = 1'b0;
  logic disparea = 1'b0;
  logic [9:0] hsp = 10'd100;
  logic [9:0] vsp = 10'd100;
  logic [4:0] btn = 5'd0;
  logic [3:0] vga_r, vga_g, vga_b, score1, score2;
  logic game_over;
  int total = 0;
  int bad = 0;
  int m_p1, m_p2, m_bx, m_by, m_dx, m_dy, m_s1, m_s2, m_over;

  pong_frame_ctrl dut (
    .vga_clk(vga_clk), .rst_n(rst_n), .hsp(hsp), .vsp(vsp), .disparea(disparea), .btn(btn),
    .vga_r(vga_r), .vga_g(vga_g), .vga_b(vga_b), .score1(score1), .score2(score2), .game_over(game_over)
  );

  always #5 vga_clk = ~vga_clk;

  task automatic chk(input string tag, input int got, input int exp);
    total++;
    if (got != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge vga_clk);
  endtask

  function automatic void model_reset();
    m_p1 = 210; m_p2 = 210; m_bx = 316; m_by = 236; m_dx = 1; m_dy = 1;
    m_s1 = 0; m_s2 = 0; m_over = 0;
  endfunction

  function automatic int move(input int y, input bit up, input bit dn);
    if (up && !dn) y = y - 4;
    if (dn && !up) y = y + 4;
    return y < 0 ? 0 : y > 420 ? 420 : y;
  endfunction

  // one whole frame of game rules applied at once
  function automatic void model_frame(input logic [3:0] b);
    int ny;
    bit up2, dn2;
    up2 = b[2];
    dn2 = b[3];
`ifdef PONG_AI_EN
    up2 = (m_by + 4) < (m_p2 + 30 - 4);
    dn2 = (m_by + 4) > (m_p2 + 30 + 4);
`endif
    m_p1 = move(m_p1, b[0], b[1]);
    m_p2 = move(m_p2, up2, dn2);
    if (m_over) return;
    m_bx += m_dx ? 2 : -2;
    m_by += m_dy ? 2 : -2;
    ny = m_by;
    if (m_by <= 0) begin m_dy = 1; ny = 0; end
    else if (m_by >= 472) begin m_dy = 0; ny = 472; end
    if (!m_dx && m_bx <= 24 && m_by < m_p1 + 60 && m_by + 8 > m_p1) begin m_dx = 1; m_bx = 24; end
    else if (m_dx && m_bx >= 608 && m_by < m_p2 + 60 && m_by + 8 > m_p2) begin m_dx = 0; m_bx = 608; end
    m_by = ny;
    if (m_bx <= 0) begin m_s2++; m_bx = 316; m_by = 236; m_dx = 0; end
    else if (m_bx >= 632) begin m_s1++; m_bx = 316; m_by = 236; m_dx = 1; end
    if (m_s1 == 9 || m_s2 == 9) m_over = 1;
  endfunction

  function automatic int ref_pix(input int h, input int v, input bit d);
    bit rect;
    if (!d) return 0;
    rect = (h >= m_bx && h < m_bx + 8 && v >= m_by && v < m_by + 8) ||
           (h >= 16 && h < 24 && v >= m_p1 && v < m_p1 + 60) ||
           (h >= 616 && h < 624 && v >= m_p2 && v < m_p2 + 60);
    if (rect) return 15;
    return (h >= 318 && h <= 321 && v % 16 < 8) ? 8 : 0;
  endfunction

  task automatic chk_state();
    chk("p1_y", dut.p1_y_q, m_p1);
    chk("p2_y", dut.p2_y_q, m_p2);
    chk("ball_x", dut.ball_x_q, m_bx);
    chk("ball_y", dut.ball_y_q, m_by);
    chk("dx", dut.dx_q, m_dx);
    chk("dy", dut.dy_q, m_dy);
    chk("score1", score1, m_s1);
    chk("score2", score2, m_s2);
    chk("game_over", game_over, m_over);
  endtask

  task automatic do_frame(input logic [3:0] b);
    btn = {1'b0, b};
    hsp = 10'd100;
    vsp = 10'd100;
    cyc(3);
    vsp = 10'd480;
    hsp = 10'd0;
    cyc(1);
    hsp = 10'd1;
    cyc(7);
    model_frame(b);
    chk_state();
  endtask

  task automatic serve();
    btn = 5'b10000;
    cyc(4);
    btn = 5'b00000;
    cyc(4);
    if (m_over) begin m_s1 = 0; m_s2 = 0; m_over = 0; end
    chk("serve_s1", score1, m_s1);
    chk("serve_s2", score2, m_s2);
    chk("serve_go", game_over, m_over);
  endtask

  task automatic pix(input int h, input int v, input bit d);
    int e;
    hsp = 10'(h);
    vsp = 10'(v);
    disparea = d;
    cyc(1);
    e = ref_pix(h, v, d);
    chk("pix_r", vga_r, e);
    chk("pix_g", vga_g, e);
    chk("pix_b", vga_b, e);
  endtask

  task automatic rand_pix();
    int h, v;
    if ($urandom_range(0, 1)) begin
      h = m_bx + int'($urandom_range(0, 11)) - 2;
      v = m_by + int'($urandom_range(0, 11)) - 2;
      h = h < 0 ? 0 : h > 639 ? 639 : h;
      v = v < 0 ? 0 : v > 479 ? 479 : v;
    end else begin
      h = $urandom_range(0, 639);
      v = $urandom_range(0, 479);
    end
    pix(h, v, $urandom_range(0, 7) != 0);
  endtask

  // p1 chases the ball, p2 runs away from it, so p1 wins the game
  function automatic logic [3:0] lopsided();
    logic [3:0] b;
    b = 4'b0;
    b[0] = (m_by + 4) < (m_p1 + 30 - 4);
    b[1] = (m_by + 4) > (m_p1 + 30 + 4);
    b[2] = (m_by + 4) >= (m_p2 + 30);
    b[3] = (m_by + 4) < (m_p2 + 30);
    return b;
  endfunction

  initial begin
    model_reset();
    cyc(2);
    chk("rst_r", vga_r, 0);
    chk("rst_g", vga_g, 0);
    chk("rst_b", vga_b, 0);
    chk_state();
    rst_n = 1'b1;
    cyc(2);
    chk_state();
    do_frame(4'b0000);
    chk("first_bx", dut.ball_x_q, 318);
    chk("first_by", dut.ball_y_q, 238);
    pix(320, 0, 1'b1);
    chk("ctr_line", vga_r, 8);
    pix(320, 0, 1'b0);
    chk("blank", vga_g, 0);
    for (int i = 0; i < 60; i++) begin
      do_frame(4'b0001);
      if (i == 51) chk("p1_near_top", dut.p1_y_q, 2);
      if (i == 52) chk("p1_top", dut.p1_y_q, 0);
    end
    chk("p1_hold_top", dut.p1_y_q, 0);
    do_frame(4'b0010);
    do_frame(4'b0010);
    do_frame(4'b0011);
    chk("p1_both", dut.p1_y_q, 8);
    for (int f = 0; f < 3000 && !m_over; f++) begin
      do_frame(lopsided());
      if (f % 8 == 0) rand_pix();
    end
    chk("reached_over", m_over, 1);
    chk("over_s1", score1, 9);
    for (int f = 0; f < 4; f++) do_frame(4'(($urandom_range(0, 15))));
    chk("frozen_x", dut.ball_x_q, 316);
    rand_pix();
    serve();
    chk("cleared", score1, 0);
    for (int f = 0; f < 600; f++) begin
      do_frame(4'($urandom_range(0, 15)));
      rand_pix();
      if ($urandom_range(0, 49) == 0) serve();
    end
    btn = 5'b00000;
    cyc(3);
    vsp = 10'd480;
    hsp = 10'd0;
    cyc(1);
    hsp = 10'd1;
    cyc(1);
    rst_n = 1'b0;
    #1;
    model_reset();
    chk_state();
    chk("mid_rst_col", vga_r, 0);
    cyc(2);
    rst_n = 1'b1;
    cyc(2);
    do_frame(4'b0000);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/pong_frame_ctrl.md
PONG_FRAME_CTRL -- requirements
Module: pong_frame_ctrl

Interface
REQ-001 Parameter PADDLE_H, 60, paddle height in lines.
REQ-002 Parameter PADDLE_W, 8, paddle width in pixels.
REQ-003 Parameter BALL_SZ, 8, ball edge length in pixels.
REQ-004 Parameter PADDLE_STEP, 4, paddle lines moved per frame.
REQ-005 Parameter BALL_STEP, 2, ball pixels moved per frame per axis.
REQ-006 Port vga_clk  in  1  pixel clock; the only clock.
REQ-007 Port rst_n  in  1  asynchronous active-low reset.
REQ-008 Port hsp  in  10  horizontal pixel position from the sync generator.
REQ-009 Port vsp  in  10  vertical line position from the sync generator.
REQ-010 Port disparea  in  1  visible-area flag.
REQ-011 Port btn  in  5  raw, asynchronous buttons: {serve, p2_dn, p2_up, p1_dn, p1_up}, active-high.
REQ-012 Port vga_r, vga_g, vga_b  out  4 each  registered pixel colour.
REQ-013 Port score1, score2  out  4 each  player scores, 0..9.
REQ-014 Port game_over  out  1  high while either score equals 9.

Function
REQ-015 btn SHALL pass through a 2-flop synchroniser; logic uses synchronised values only.
REQ-016 frame_tick SHALL pulse for one cycle when vsp==480 && hsp==0.
REQ-017 FSM states SHALL be WAIT, PADDLE, BALL, HIT, SCORE, OVER; each non-WAIT/OVER state lasts exactly 1 cycle.
REQ-018 WAIT->PADDLE on frame_tick; PADDLE->BALL->HIT->SCORE->WAIT unconditionally; SCORE->OVER when a score reaches 9.
REQ-019 PADDLE: up subtracts PADDLE_STEP, down adds it; clamp to 0..480-PADDLE_H; up and down together => no move.
REQ-020 BALL: ball_x += dx ? +BALL_STEP : -BALL_STEP; ball_y likewise with dy; intermediate arithmetic 11-bit signed.
REQ-021 HIT: ball_y<=0 => dy=down, ball_y=0; ball_y>=480-BALL_SZ => dy=up, ball_y=480-BALL_SZ.
REQ-022 HIT: left paddle at x 16..16+PADDLE_W-1; if dx=left, ball_x<=16+PADDLE_W and ball rows overlap p1 rows => dx=right, ball_x=16+PADDLE_W.
REQ-023 HIT: right paddle at x 616..616+PADDLE_W-1; mirror rule, ball_x set to 616-BALL_SZ.
REQ-024 SCORE: ball_x<=0 => score2+1; ball_x>=640-BALL_SZ => score1+1; on either, ball re-centred at (316,236), dx toward the conceding player, dy unchanged.
REQ-025 Wall and paddle contact in the same HIT cycle SHALL both apply.
REQ-026 OVER: ball frozen at centre, paddles still update; a serve rising edge clears both scores and returns to WAIT.
REQ-027 frame_tick outside WAIT SHALL be ignored.
REQ-028 Render, 1-cycle latency from hsp/vsp: disparea=0 => black; ball or paddle pixel => F/F/F; hsp 318..321 and vsp[3]==0 => 8/8/8; else black.
REQ-029 Paddle and ball rectangles SHALL take priority over the centre line.

Reset
REQ-030 rst_n low SHALL asynchronously force: colours 0, scores 0, game_over 0, FSM WAIT, synchronisers 0.
REQ-031 Reset values: p1_y=p2_y=(480-PADDLE_H)/2, ball (316,236), dx=right, dy=down.
REQ-032 Reset mid-update SHALL abandon the sequence with no partial register update surviving.

Configuration
REQ-033 Macro PONG_AI_EN defined: p2 paddle SHALL ignore p2 buttons and move PADDLE_STEP toward ball_y+BALL_SZ/2 when its centre differs by more than PADDLE_STEP, clamped as REQ-019.
REQ-034 PONG_AI_EN undefined: p2 SHALL follow btn[3:2] per REQ-019.

Verification
REQ-035 Reset released, 1 frame, no buttons -> ball (318,238), paddles 210, scores 0.
REQ-036 p1_up held 60 frames -> p1_y 0 after frame 53, holds at 0; p1_up+p1_dn together -> p1_y unchanged.
REQ-037 Ball forced to y=1, dy=up -> next frame ball_y 0, dy=down.
REQ-038 Ball to left edge with p1 away -> score2 1, ball (316,236), dx=left; with p1 aligned -> dx=right, ball_x 24, no score.
REQ-039 score1 at 8, point to p1 -> score1 9, game_over 1, ball frozen; serve pulse -> scores 0, game_over 0.
REQ-040 Pixel at hsp=320, vsp=0, disparea=1 -> colour 8/8/8 one cycle later; disparea=0 -> 0/0/0.
